// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: pattern-in / LED-out bundle for the LED fader stage.
//   PATTERN        target on/off pattern, 1 = LED fully on
//   PATTERN_VALID  1-cycle strobe, PATTERN sampled while high
//   USER_LED       active-low LED pins (0 = lit), registered in the fader
//   BUSY           high while any LED level differs from its target
// master: pattern source side; slave: the fader itself.
interface led_pwm_fader_if #(
  parameter int unsigned NUM_LEDS = 8
);
  logic [NUM_LEDS-1:0] PATTERN;
  logic                PATTERN_VALID;
  logic [NUM_LEDS-1:0] USER_LED;
  logic                BUSY;

  modport master (
    output PATTERN,
    output PATTERN_VALID,
    input  USER_LED,
    input  BUSY
  );

  modport slave (
    input  PATTERN,
    input  PATTERN_VALID,
    output USER_LED,
    output BUSY
  );
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: downstream LED stage. Each LED ramps its brightness level
// toward an on/off target in FADE_STEP increments once per fade tick, and the
// level is rendered as PWM against one shared free-running counter.
// Ports:
//   SYS_CLK   in   system clock, only clock domain
//   RESET_N   in   asynchronous active-low reset
//   led_bus   slave modport of led_pwm_fader_if
//             (PATTERN, PATTERN_VALID in; USER_LED, BUSY out)
// Optional feature: define LED_GAMMA_EN for an approximate square-law gamma
// on the duty cycle (adds one register stage, compare-to-pin latency 2).
module led_pwm_fader #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned STEP_DIV  = 50000,
  parameter int unsigned FADE_STEP = 4
) (
  input  logic            SYS_CLK,
  input  logic            RESET_N,
  led_pwm_fader_if.slave  led_bus
);
  localparam int unsigned LMAX  = (1 << PWM_BITS) - 1;
  localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(LMAX - 1);
  localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS + 1)'(FADE_STEP);

  logic [PRE_W-1:0]    prescaler;
  logic                fade_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] target     [NUM_LEDS];
  logic [PWM_BITS-1:0] level      [NUM_LEDS];
  logic [PWM_BITS-1:0] level_next [NUM_LEDS];
  logic [PWM_BITS-1:0] duty       [NUM_LEDS];
  logic [NUM_LEDS-1:0] lit;
  logic [NUM_LEDS-1:0] differ;
  logic [PWM_BITS:0]   lvl_x, tgt_x, sum_x;

  assign fade_tick = (prescaler == PRE_LAST);

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= fade_tick ? '0 : prescaler + PRE_W'(1);
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
    end
  end

  // Saturating step toward target, computed one bit wider so level+step
  // and target+step cannot wrap.
  always_comb begin
    lvl_x = '0;
    tgt_x = '0;
    sum_x = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      lvl_x = {1'b0, level[i]};
      tgt_x = {1'b0, target[i]};
      sum_x = lvl_x + STEP_X;
      level_next[i] = level[i];
      if (lvl_x < tgt_x) begin
        level_next[i] = (sum_x > tgt_x) ? target[i] : sum_x[PWM_BITS-1:0];
      end else if (lvl_x > tgt_x) begin
        level_next[i] = (lvl_x <= tgt_x + STEP_X) ? target[i]
                                                  : PWM_BITS'(lvl_x - STEP_X);
      end
    end
  end

  // level_next is built from the target register, so a tick coinciding with
  // a new pattern still steps toward the previous target.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        target[i] <= '0;
        level[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (led_bus.PATTERN_VALID) target[i] <= led_bus.PATTERN[i] ? '1 : '0;
        if (fade_tick)             level[i]  <= level_next[i];
      end
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] lvl_w, prod;

  always_comb begin
    lvl_w = '0;
    prod  = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      lvl_w = (2*PWM_BITS)'(level[i]);
      prod  = lvl_w * (lvl_w + (2*PWM_BITS)'(1));
    end
  end

  // level*(level+1) >> PWM_BITS keeps both endpoints exact (0 and LMAX).
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        duty[i] <= PWM_BITS'(((2*PWM_BITS)'(level[i]) *
                              ((2*PWM_BITS)'(level[i]) + (2*PWM_BITS)'(1))) >> PWM_BITS);
      end
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] = level[i];
  end
`endif

  always_comb begin
    lit    = '0;
    differ = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      lit[i]    = (duty[i] > pwm_cnt);
      differ[i] = (level[i] != target[i]);
    end
  end

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) led_bus.USER_LED <= '1;
    else          led_bus.USER_LED <= ~lit;
  end

  assign led_bus.BUSY = |differ;
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: scoreboard bench. Stimulus threads queue expected results
// tagged with the cycle they are due; a negedge monitor compares them.
// u_fast uses STEP_DIV=4, FADE_STEP=64; u_slow (STEP_DIV=600) holds a
// level long enough to measure PWM duty over full 255-cycle windows.
module tb_led_pwm_fader;
  logic clk = 1'b0;
  logic fast_rst_n, slow_rst_n;
  always #5 clk = ~clk;

  led_pwm_fader_if #(.NUM_LEDS(8)) fast_if ();
  led_pwm_fader_if #(.NUM_LEDS(8)) slow_if ();

  led_pwm_fader #(.NUM_LEDS(8), .PWM_BITS(8), .STEP_DIV(4), .FADE_STEP(64)) u_fast (
    .SYS_CLK(clk), .RESET_N(fast_rst_n), .led_bus(fast_if));
  led_pwm_fader #(.NUM_LEDS(8), .PWM_BITS(8), .STEP_DIV(600), .FADE_STEP(64)) u_slow (
    .SYS_CLK(clk), .RESET_N(slow_rst_n), .led_bus(slow_if));

`ifdef LED_GAMMA_EN
  localparam int HALF_LOWS = 64;
`else
  localparam int HALF_LOWS = 128;
`endif

  typedef struct {
    int          kind;   // 0 pins+busy, 1 fast level0, 2 slow window, 3 busy
    int unsigned due;
    logic [7:0]  exp_led;
    logic        exp_busy;
    int          exp_val;
    string       name;
  } item_t;

  item_t       sbq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned tcyc = 0;
  int unsigned cyc, scyc;
  logic        lo_buf [255];
  logic        hi_buf [255];

  always @(posedge clk) tcyc <= tcyc + 1;
  always @(posedge clk or negedge fast_rst_n)
    if (!fast_rst_n) cyc <= 0; else cyc <= cyc + 1;
  always @(posedge clk or negedge slow_rst_n)
    if (!slow_rst_n) scyc <= 0; else scyc <= scyc + 1;

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic align(input int unsigned r);
    sync();
    while (cyc % 4 != r) sync();
  endtask

  task automatic push(input int kind, input string n, input int unsigned d,
                      input logic [7:0] led, input logic busy, input int v);
    item_t it;
    it.kind = kind; it.due = tcyc + d; it.exp_led = led;
    it.exp_busy = busy; it.exp_val = v; it.name = n;
    sbq.push_back(it);
  endtask

  task automatic push_pins(input string n, input int unsigned d, input logic [7:0] led, input logic busy);
    push(0, n, d, led, busy, 0);
  endtask
  task automatic push_lvl(input string n, input int unsigned d, input int v);
    push(1, n, d, 8'h00, 1'b0, v);
  endtask
  task automatic push_win(input string n, input int unsigned d, input int v);
    push(2, n, d, 8'h00, 1'b0, v);
  endtask
  task automatic push_busy(input string n, input int unsigned d, input logic b);
    push(3, n, d, 8'h00, b, 0);
  endtask

  task automatic load_fast(input logic [7:0] p);
    fast_if.PATTERN = p; fast_if.PATTERN_VALID = 1'b1;
    sync();
    fast_if.PATTERN_VALID = 1'b0;
  endtask
  task automatic load_slow(input logic [7:0] p);
    slow_if.PATTERN = p; slow_if.PATTERN_VALID = 1'b1;
    sync();
    slow_if.PATTERN_VALID = 1'b0;
  endtask

  // Monitor: records slow-LED window history, services due expectations.
  always @(negedge clk) begin
    item_t it;
    int lo, hi;
    lo_buf[tcyc % 255] = ~slow_if.USER_LED[0];
    hi_buf[tcyc % 255] = (slow_if.USER_LED[7:1] != 7'h7F);
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due == tcyc) begin
        it = sbq[i];
        sbq.delete(i);
        case (it.kind)
          0: begin
            checks++;
            if (fast_if.USER_LED !== it.exp_led || fast_if.BUSY !== it.exp_busy) begin
              errors++;
              $display("FAIL %s led=%h busy=%b expected led=%h busy=%b",
                       it.name, fast_if.USER_LED, fast_if.BUSY, it.exp_led, it.exp_busy);
            end
          end
          1: begin
            checks++;
            if (int'(u_fast.level[0]) != it.exp_val) begin
              errors++;
              $display("FAIL %s level0=%0d expected %0d", it.name, u_fast.level[0], it.exp_val);
            end
          end
          2: begin
            lo = 0; hi = 0;
            for (int k = 0; k < 255; k++) begin
              if (lo_buf[k]) lo++;
              if (hi_buf[k]) hi++;
            end
            checks++;
            if (lo != it.exp_val) begin
              errors++;
              $display("FAIL %s lit_cycles=%0d expected %0d", it.name, lo, it.exp_val);
            end
            checks++;
            if (hi != 0) begin
              errors++;
              $display("FAIL %s_others upper_lit_cycles=%0d expected 0", it.name, hi);
            end
          end
          default: begin
            checks++;
            if (fast_if.BUSY !== it.exp_busy) begin
              errors++;
              $display("FAIL %s busy=%b expected %b", it.name, fast_if.BUSY, it.exp_busy);
            end
          end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d expected completion", tcyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n0;
    fast_rst_n = 1'b0; slow_rst_n = 1'b0;
    fast_if.PATTERN = '0; fast_if.PATTERN_VALID = 1'b0;
    slow_if.PATTERN = '0; slow_if.PATTERN_VALID = 1'b0;
    repeat (3) sync();

    // Pattern strobe while held in reset is ignored.
    fast_if.PATTERN = 8'hFF; fast_if.PATTERN_VALID = 1'b1;
    push_pins("rst_pv", 0, 8'hFF, 1'b0);
    sync();
    fast_if.PATTERN_VALID = 1'b0;
    push_pins("rst_after_pv", 0, 8'hFF, 1'b0);
    sync();
    fast_rst_n = 1'b1; slow_rst_n = 1'b1;
    push_pins("idle_1", 1, 8'hFF, 1'b0);
    push_pins("idle_3", 3, 8'hFF, 1'b0);
    push_lvl("idle_lvl", 1, 0);

    fork
      begin : fast_thread
        // Ramp 0 -> 255 on LED0, pattern loaded away from a tick.
        align(0);
        push_pins("t2_pre", 0, 8'hFF, 1'b0);
        push_pins("t2_busy_rise", 1, 8'hFF, 1'b1);
        push_lvl("t2_l_before_tick", 3, 0);
        push_lvl("t2_l64", 4, 64);
        push_lvl("t2_l128", 8, 128);
        push_lvl("t2_l192", 12, 192);
        push_busy("t2_busy_hold", 15, 1'b1);
        push_lvl("t2_l255", 16, 255);
        push_busy("t2_busy_fall", 16, 1'b0);
        push_pins("t2_full_a", 18, 8'hFE, 1'b0);
        push_pins("t2_full_b", 40, 8'hFE, 1'b0);
        load_fast(8'h01);
        repeat (45) sync();
        load_fast(8'h00);
        repeat (30) sync();

        // Reverse mid-ramp at level 128.
        align(0);
        n0 = tcyc;
        push_lvl("t4_l64_up", 4, 64);
        load_fast(8'h01);
        while (tcyc != n0 + 8) sync();
        push_lvl("t4_l128", 0, 128);
        push_lvl("t4_l128_hold", 3, 128);
        push_lvl("t4_l64_dn", 4, 64);
        push_busy("t4_busy_hold", 7, 1'b1);
        push_lvl("t4_l0", 8, 0);
        push_busy("t4_busy_fall", 8, 1'b0);
        push_lvl("t4_no_underflow", 12, 0);
        load_fast(8'h00);
        repeat (20) sync();

        // Pattern on the tick cycle: that tick still targets the old 0.
        align(3);
        push_lvl("coinc_old_tgt", 1, 0);
        push_busy("coinc_busy", 1, 1'b1);
        push_lvl("coinc_still0", 4, 0);
        push_lvl("coinc_next_tick", 5, 64);
        load_fast(8'h01);
        repeat (30) sync();
      end
      begin : slow_thread
        while (scyc < 100) sync();
        push_win("pwm_half", 1400, HALF_LOWS);
        push_win("pwm_full", 2600, 255);
        load_slow(8'h01);
        repeat (2620) sync();
      end
    join

    // Async reset mid-fade at level 192.
    load_fast(8'h00);
    repeat (30) sync();
    align(0);
    n0 = tcyc;
    push_lvl("t5_l192", 12, 192);
    load_fast(8'h01);
    while (tcyc != n0 + 13) sync();
    fast_rst_n = 1'b0;
    push_pins("t5_async_pins", 0, 8'hFF, 1'b0);
    push_lvl("t5_async_lvl", 0, 0);
    sync();
    fast_rst_n = 1'b1;
    push_pins("t5_rel_1", 1, 8'hFF, 1'b0);
    push_pins("t5_rel_5", 5, 8'hFF, 1'b0);
    push_pins("t5_rel_20", 20, 8'hFF, 1'b0);
    push_lvl("t5_rel_lvl", 5, 0);
    repeat (30) sync();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL unserviced pending=%0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
